// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline sequencing controller:
// FSM state encoding, next-PC source encodings and the default handler address.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_EXC   = 2'd2,
      ST_ERET  = 2'd3
   } state_e;

   localparam logic [1:0] PCSEL_NPC     = 2'd0;
   localparam logic [1:0] PCSEL_HANDLER = 2'd1;
   localparam logic [1:0] PCSEL_EPC     = 2'd2;

   localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;

   // Saturating 8-bit increment used by the stall watchdog.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Counts consecutive applied stall cycles and raises a sticky timeout flag
// once the count reaches STALL_LIMIT-1 while still stalled.
module stall_watchdog
   import pipe_pkg::*;
#(
   parameter int STALL_LIMIT = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic stall_i,
   output logic timeout_o
);

   localparam logic [7:0] LIMIT_M1 = 8'(STALL_LIMIT - 1);

   logic [7:0] cnt_q, cnt_d;
   logic       flag_q, flag_d;

   // Next counter value and sticky flag.
   always_comb begin
      cnt_d  = 8'd0;
      flag_d = flag_q;
      if (stall_i) begin
         cnt_d  = sat_inc8(cnt_q);
         flag_d = flag_q | (cnt_q >= LIMIT_M1);
      end else begin
         cnt_d  = 8'd0;
         flag_d = flag_q;
      end
   end

   // Counter and flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= 8'd0;
         flag_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         flag_q <= flag_d;
      end
   end

   assign timeout_o = flag_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: Mealy enables/clears, next-PC select and watchdog.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter logic [31:0] HANDLER_PC  = HANDLER_PC_DEFAULT,
   parameter int          STALL_LIMIT = 64,
   parameter int          CNT_W       = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Hazard_Stall,
   input  logic        MDU_Stall,
   input  logic        Req,
   input  logic        D_Eret,
   input  logic [31:0] EPC,
   output logic        PC_WE,
   output logic        F_D_RegWE,
   output logic        D_E_RegWE,
   output logic        E_M_RegWE,
   output logic        M_W_RegWE,
   output logic        F_D_clear,
   output logic        D_E_clear,
   output logic        E_M_clear,
   output logic        M_W_clear,
   output logic        Req_Out,
   output logic [1:0]  PC_Sel,
   output logic [31:0] Redirect_PC,
   output logic        Stall_Timeout
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0] Stall_Cnt,
   output logic [CNT_W-1:0] Flush_Cnt,
   output logic [CNT_W-1:0] Eret_Cnt
`endif
);

   state_e state_q, state_d;
   logic   stall_apply;
   logic   eret_take;

   // Counter width must be at least one bit.
   if (CNT_W < 1) begin : g_cnt_w_invalid
   end

   // Priority: reset > Req > EXC bubble cycle > stall > eret > normal flow.
   always_comb begin
      PC_WE       = 1'b1;
      F_D_RegWE   = 1'b1;
      D_E_RegWE   = 1'b1;
      E_M_RegWE   = 1'b1;
      M_W_RegWE   = 1'b1;
      F_D_clear   = 1'b0;
      D_E_clear   = 1'b0;
      E_M_clear   = 1'b0;
      M_W_clear   = 1'b0;
      Req_Out     = 1'b0;
      PC_Sel      = PCSEL_NPC;
      stall_apply = 1'b0;
      eret_take   = 1'b0;
      state_d     = ST_RUN;
      if (reset) begin
         state_d = ST_RUN;
      end else if (Req) begin
         Req_Out = 1'b1;
         PC_Sel  = PCSEL_HANDLER;
         state_d = ST_EXC;
      end else if (state_q == ST_EXC) begin
         state_d = ST_RUN;
      end else if (Hazard_Stall | MDU_Stall) begin
         PC_WE       = 1'b0;
         F_D_RegWE   = 1'b0;
         D_E_clear   = 1'b1;
         stall_apply = 1'b1;
         state_d     = ST_STALL;
      end else if (D_Eret) begin
         PC_Sel    = PCSEL_EPC;
         F_D_clear = 1'b1;
         eret_take = 1'b1;
         state_d   = ST_ERET;
      end else begin
         state_d = ST_RUN;
      end
      Redirect_PC = (PC_Sel == PCSEL_HANDLER) ? HANDLER_PC : EPC;
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   stall_watchdog #(
      .STALL_LIMIT(STALL_LIMIT)
   ) u_watchdog (
      .clk      (clk),
      .reset    (reset),
      .stall_i  (stall_apply),
      .timeout_o(Stall_Timeout)
   );

`ifdef PIPE_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0] eret_cnt_q, eret_cnt_d;

   // Event counters wrap naturally at 2^CNT_W.
   always_comb begin
      stall_cnt_d = stall_cnt_q + CNT_W'(stall_apply);
      flush_cnt_d = flush_cnt_q + CNT_W'(Req_Out);
      eret_cnt_d  = eret_cnt_q + CNT_W'(eret_take);
   end

   // Performance counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         eret_cnt_q  <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         eret_cnt_q  <= eret_cnt_d;
      end
   end

   assign Stall_Cnt = stall_cnt_q;
   assign Flush_Cnt = flush_cnt_q;
   assign Eret_Cnt  = eret_cnt_q;
`else
   logic unused_eret_take;
   assign unused_eret_take = eret_take;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed, table-driven bench for pipe_ctrl (watchdog limit 4); counter checks
// are compiled in when PIPE_CTRL_PERF_EN is defined.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        Hazard_Stall, MDU_Stall, Req, D_Eret;
   logic [31:0] EPC;
   logic        PC_WE, F_D_RegWE, D_E_RegWE, E_M_RegWE, M_W_RegWE;
   logic        F_D_clear, D_E_clear, E_M_clear, M_W_clear;
   logic        Req_Out, Stall_Timeout;
   logic [1:0]  PC_Sel;
   logic [31:0] Redirect_PC;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] Stall_Cnt, Flush_Cnt, Eret_Cnt;
`endif

   int checks = 0;
   int errors = 0;

   pipe_ctrl #(
      .HANDLER_PC (32'h0000_4180),
      .STALL_LIMIT(4),
      .CNT_W      (32)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .Hazard_Stall (Hazard_Stall),
      .MDU_Stall    (MDU_Stall),
      .Req          (Req),
      .D_Eret       (D_Eret),
      .EPC          (EPC),
      .PC_WE        (PC_WE),
      .F_D_RegWE    (F_D_RegWE),
      .D_E_RegWE    (D_E_RegWE),
      .E_M_RegWE    (E_M_RegWE),
      .M_W_RegWE    (M_W_RegWE),
      .F_D_clear    (F_D_clear),
      .D_E_clear    (D_E_clear),
      .E_M_clear    (E_M_clear),
      .M_W_clear    (M_W_clear),
      .Req_Out      (Req_Out),
      .PC_Sel       (PC_Sel),
      .Redirect_PC  (Redirect_PC),
      .Stall_Timeout(Stall_Timeout)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .Stall_Cnt    (Stall_Cnt),
      .Flush_Cnt    (Flush_Cnt),
      .Eret_Cnt     (Eret_Cnt)
`endif
   );

   always #5 clk = ~clk;

   // {WE pc,fd,de,em,mw | clr fd,de,em,mw | req_out | pc_sel[1:0] | timeout}
   localparam logic [12:0] C_NORM = 13'b11111_0000_0_00_0;
   localparam logic [12:0] C_STL  = 13'b00111_0100_0_00_0;
   localparam logic [12:0] C_REQ  = 13'b11111_0000_1_01_0;
   localparam logic [12:0] C_ERT  = 13'b11111_1000_0_10_0;

   typedef struct {
      logic        haz, mdu, req, eret;
      logic [31:0] epc;
      logic [12:0] ctl;
      logic [31:0] redir;
   } vec_t;

   vec_t vecs[17];

   function automatic vec_t mk(input logic h, input logic m, input logic r, input logic e,
                               input logic [31:0] epc, input logic [12:0] ctl,
                               input logic [31:0] redir);
      vec_t v;
      v.haz = h; v.mdu = m; v.req = r; v.eret = e;
      v.epc = epc; v.ctl = ctl; v.redir = redir;
      return v;
   endfunction

   function automatic logic [12:0] ctl_now();
      return {PC_WE, F_D_RegWE, D_E_RegWE, E_M_RegWE, M_W_RegWE,
              F_D_clear, D_E_clear, E_M_clear, M_W_clear,
              Req_Out, PC_Sel, Stall_Timeout};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic h, input logic m, input logic r, input logic e,
                        input logic [31:0] epc);
      Hazard_Stall = h; MDU_Stall = m; Req = r; D_Eret = e; EPC = epc;
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1000);

      vecs[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1000, C_NORM, 32'h0000_1000);
      vecs[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1000, C_STL,  32'h0000_1000);
      vecs[2]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1000, C_STL,  32'h0000_1000);
      vecs[3]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1000, C_STL,  32'h0000_1000);
      vecs[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1000, C_NORM, 32'h0000_1000);
      vecs[5]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_1000, C_REQ,  32'h0000_4180);
      vecs[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1000, C_NORM, 32'h0000_1000);
      vecs[7]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1000, C_STL,  32'h0000_1000);
      vecs[8]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3010, C_ERT,  32'h0000_3010);
      vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3010, C_NORM, 32'h0000_3010);
      vecs[10] = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_3010, C_STL,  32'h0000_3010);
      vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3010, C_ERT,  32'h0000_3010);
      vecs[12] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3010, C_STL,  32'h0000_3010);
      vecs[13] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_3010, C_REQ,  32'h0000_4180);
      vecs[14] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_3010, C_REQ,  32'h0000_4180);
      vecs[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3010, C_NORM, 32'h0000_3010);
      vecs[16] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3010, C_ERT,  32'h0000_3010);

      // Reset held for two cycles.
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("reset_ctl", 32'(ctl_now()), 32'(C_NORM));
      chk("reset_redirect", Redirect_PC, 32'h0000_1000);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Table-driven sequence from RUN.
      for (int i = 0; i < 17; i++) begin
         drive(vecs[i].haz, vecs[i].mdu, vecs[i].req, vecs[i].eret, vecs[i].epc);
         @(negedge clk);
         chk($sformatf("vec%0d_ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
         chk($sformatf("vec%0d_redirect", i), Redirect_PC, vecs[i].redir);
         @(posedge clk);
         #1;
      end

      // Reset mid-EXC must return to RUN: a following MDU stall is applied.
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_1000);
      @(posedge clk);
      #1;
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1000);
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1000);
      @(negedge clk);
      chk("exc_reset_stall", 32'(ctl_now()), 32'(C_STL));
      @(posedge clk);
      #1;

      // Watchdog: limit 4, flag rises after the 4th consecutive stall edge.
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1000);
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1000);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("wdog_edge%0d", k), 32'(Stall_Timeout), (k == 4) ? 32'd1 : 32'd0);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1000);
      repeat (2) @(posedge clk);
      #1;
      chk("wdog_sticky", 32'(Stall_Timeout), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("wdog_reset", 32'(Stall_Timeout), 32'd0);
      reset = 1'b0;

`ifdef PIPE_CTRL_PERF_EN
      // Performance counters: 5 stalls, 2 Req cycles, 1 eret redirect.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1000);
      repeat (5) @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_1000);
      repeat (2) @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1000);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3010);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3010);
      @(posedge clk);
      #1;
      chk("perf_stall_cnt", Stall_Cnt, 32'd5);
      chk("perf_flush_cnt", Flush_Cnt, 32'd2);
      chk("perf_eret_cnt", Eret_Cnt, 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("perf_reset", Stall_Cnt | Flush_Cnt | Eret_Cnt, 32'd0);
      reset = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline sequencing controller for the five-stage MIPS core. Each cycle it produces the write-enable and clear controls for the PC and the F_D, D_E, E_M and M_W pipeline registers. It arbitrates between hazard stalls, multiply/divide busy stalls, exception/interrupt requests taken at M, and `eret` redirection, and selects the next-PC source. It holds a small FSM plus a stall watchdog, and can optionally hold performance counters.

## Interface
- `HANDLER_PC`, default 32'h0000_4180: exception handler entry address.
- `STALL_LIMIT`, default 64: consecutive stall cycles before the watchdog flag is set (range 2..255).
- `CNT_W`, default 32: performance counter width.
- `clk` in 1: single clock; every register updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `Hazard_Stall` in 1: D-stage Tuse/Tnew conflict.
- `MDU_Stall` in 1: D-stage instruction needs the MDU while it is busy.
- `Req` in 1: CP0 takes an exception or interrupt at M (combinational, same cycle).
- `D_Eret` in 1: `eret` is in D.
- `EPC` in 32: return address from CP0.
- `PC_WE` out 1: PC register enable.
- `F_D_RegWE`, `D_E_RegWE`, `E_M_RegWE`, `M_W_RegWE` out 1 each: pipeline register enables.
- `F_D_clear`, `D_E_clear`, `E_M_clear`, `M_W_clear` out 1 each: insert bubble.
- `Req_Out` out 1: flush request broadcast to all pipeline registers.
- `PC_Sel` out 2: next-PC source. 0 = NPC, 1 = `HANDLER_PC`, 2 = `EPC`.
- `Redirect_PC` out 32: `HANDLER_PC` when `PC_Sel`=1, otherwise `EPC`.
- `Stall_Timeout` out 1: sticky watchdog flag.

## Operation
- FSM states: RUN, STALL, EXC, ERET. Reset state is RUN.
- Priority each cycle: `Req` > stall (`Hazard_Stall` | `MDU_Stall`) > `D_Eret`.
- **`Req`=1 (any state):**
  - `Req_Out`=1, `PC_Sel`=1, all WE=1, all clears=0.
  - The pipeline registers apply their own Req flush.
  - Next state is EXC.
- **EXC (one cycle):**
  - Stall inputs are ignored; the pipeline holds only bubbles.
  - All WE=1, `PC_Sel`=0.
  - Next state is RUN, or EXC again if `Req` is asserted again.
- **Stall (no `Req`):**
  - `PC_WE`=0, `F_D_RegWE`=0, `D_E_clear`=1.
  - `D_E_RegWE`, `E_M_RegWE`, `M_W_RegWE` = 1.
  - Next state is STALL.
- **STALL:** behaves like RUN. It exists so the watchdog can count consecutive stall cycles. Leave when the stall drops.
- **`D_Eret` with no stall and no `Req`:**
  - `PC_Sel`=2, `F_D_clear`=1 (squash the delay-slot fetch).
  - Next state is ERET.
- **ERET (one cycle):** normal enables, `PC_Sel`=0, then RUN. A stall or `Req` in this cycle follows the priority rules above.
- **Otherwise:** all WE=1, clears=0, `PC_Sel`=0.
- **Watchdog:**
  - 8-bit counter increments while a stall is applied and clears otherwise.
  - When it reaches `STALL_LIMIT`-1 while stalled, `Stall_Timeout` is set.
  - `Stall_Timeout` clears only on reset. The counter saturates.

## Timing
- All control outputs are combinational (Mealy) from the current state and inputs. They are valid in the same cycle the inputs change.
- State, watchdog and counters are registered. They update at the next rising edge.
- During reset and on the edge after it:
  - state=RUN, all WE=1, clears=0, `Req_Out`=0, `PC_Sel`=0.
  - `Redirect_PC`=`EPC`, `Stall_Timeout`=0, counters=0.
- Reset has priority over every input. Reset asserted mid-STALL, EXC or ERET returns to RUN on the next edge.
- `Req` together with a stall: no stall is applied and the watchdog clears.
- `D_Eret` together with a stall: the stall wins and `eret` is re-evaluated the next cycle.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - Adds output ports `Stall_Cnt`, `Flush_Cnt`, `Eret_Cnt` (each `CNT_W` bits).
  - They count stall cycles, `Req` cycles and `eret` redirects.
  - They wrap modulo 2^`CNT_W` and reset to 0.
- `PIPE_CTRL_PERF_EN` undefined: these ports and registers do not exist. All other behaviour is identical.

## Structure
- Shared package (`pipe_pkg`) holds:
  - the FSM state enum;
  - the `PC_Sel` encodings (`PCSEL_NPC`, `PCSEL_HANDLER`, `PCSEL_EPC`);
  - the default `HANDLER_PC` constant.
- One sub-module, `stall_watchdog`: the saturating counter plus sticky flag, parameterised by `STALL_LIMIT`.

## Test plan
- **Reset:** `reset`=1 for 2 cycles with all inputs 0 → all WE=1, clears=0, `PC_Sel`=0, state RUN.
- **Hazard stall:** `Hazard_Stall`=1 for 3 cycles → `PC_WE`=`F_D_RegWE`=0 and `D_E_clear`=1 for exactly those 3 cycles; the 4th cycle is normal.
- **Req during stall:** `MDU_Stall`=1 and `Req`=1 in the same cycle → `Req_Out`=1, `PC_Sel`=1, `Redirect_PC`=32'h0000_4180, `PC_WE`=1; the next cycle is EXC with all WE=1.
- **eret:** `D_Eret`=1 with `EPC`=32'h0000_3010 → `PC_Sel`=2, `Redirect_PC`=32'h0000_3010, `F_D_clear`=1; the next cycle is normal.
- **Watchdog:** `STALL_LIMIT`=4 and `Hazard_Stall` held → `Stall_Timeout` rises after the 4th stall edge and stays 1 after the stall ends; reset clears it.
- **Performance counters:** with `PIPE_CTRL_PERF_EN`, apply 5 stall cycles, 2 `Req` cycles and 1 `eret` → `Stall_Cnt`=5, `Flush_Cnt`=2, `Eret_Cnt`=1.
